// File: rtl/i2c_target_responder.sv
// I2C target: START/Sr/STOP decode, address match, ACK/NACK, rx sink, tx source; define I2C_TARGET_CLK_STRETCH_EN for read stretching.
// SCL edge to action is SYNC_STAGES+1 clk; rx_ready=0 NACKs a byte; a missing tx byte stretches SCL or sends 8'hFF.
module i2c_target_responder #(
    parameter logic [6:0] TARGET_ADDR = 7'h22,
    parameter int         SYNC_STAGES = 2,
    parameter int         HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       start_det,
    output logic       stop_det,
    output logic       addr_hit,
    output logic       rw,
    output logic       tx_underrun
);

`ifdef I2C_TARGET_CLK_STRETCH_EN
    localparam bit STRETCH = 1'b1;
`else
    localparam bit STRETCH = 1'b0;
`endif

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_WR_BYTE   = 4'd3;
    localparam logic [3:0] S_WR_ACK    = 4'd4;
    localparam logic [3:0] S_RD_LOAD   = 4'd5;
    localparam logic [3:0] S_RD_BYTE   = 4'd6;
    localparam logic [3:0] S_RD_ACK    = 4'd7;
    localparam logic [3:0] S_WAIT_STOP = 4'd8;

    localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES);

    logic [SYNC_STAGES-1:0] scl_sh;
    logic [SYNC_STAGES-1:0] sda_sh;
    logic                   scl_q;
    logic                   sda_q;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_cond;
    logic                   stop_cond;
    logic [3:0]             state;
    logic [3:0]             bit_cnt;
    logic [3:0]             hold_cnt;
    logic                   hold_done;
    logic [7:0]             shreg;
    logic [7:0]             shift_in;
    logic [7:0]             load_byte;
    logic                   loaded;
    logic                   hs;

    // Idle bus is high, so synchronizers reset to 1 to avoid a phantom edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sh <= '1;
            sda_sh <= '1;
            scl_q  <= 1'b1;
            sda_q  <= 1'b1;
        end else begin
            scl_sh <= {scl_sh[SYNC_STAGES-2:0], scl_i};
            sda_sh <= {sda_sh[SYNC_STAGES-2:0], sda_i};
            scl_q  <= scl_s;
            sda_q  <= sda_s;
        end
    end

    assign scl_s      = scl_sh[SYNC_STAGES-1];
    assign sda_s      = sda_sh[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_q;
    assign scl_fall   = ~scl_s & scl_q;
    assign start_cond = scl_s & scl_q & ~sda_s & sda_q;
    assign stop_cond  = scl_s & scl_q & sda_s & ~sda_q;
    assign hold_done  = (hold_cnt == 4'd1);
    assign shift_in   = {shreg[6:0], sda_s};
    assign hs         = tx_valid & tx_ready;
    assign load_byte  = hs ? tx_data : shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            hold_cnt    <= '0;
            shreg       <= '0;
            loaded      <= 1'b0;
            scl_oe      <= 1'b0;
            sda_oe      <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_ready    <= 1'b0;
            start_det   <= 1'b0;
            stop_det    <= 1'b0;
            addr_hit    <= 1'b0;
            rw          <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            start_det   <= 1'b0;
            stop_det    <= 1'b0;
            tx_underrun <= 1'b0;
            if (hold_cnt != 4'd0)
                hold_cnt <= hold_cnt - 4'd1;
            if (scl_fall)
                hold_cnt <= HOLD_INIT;

            // Bus conditions override everything, including a same-cycle tx handshake.
            if (start_cond || stop_cond) begin
                state     <= start_cond ? S_ADDR : S_IDLE;
                start_det <= start_cond;
                stop_det  <= stop_cond;
                bit_cnt   <= '0;
                hold_cnt  <= '0;
                loaded    <= 1'b0;
                sda_oe    <= 1'b0;
                scl_oe    <= 1'b0;
                tx_ready  <= 1'b0;
                addr_hit  <= 1'b0;
            end else begin
                case (state)
                    S_ADDR, S_WR_BYTE: begin
                        if (hold_done)
                            sda_oe <= 1'b0;
                        if (scl_rise) begin
                            shreg <= shift_in;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                if (state == S_ADDR) begin
                                    if (shift_in[7:1] == TARGET_ADDR) begin
                                        state    <= S_ADDR_ACK;
                                        addr_hit <= 1'b1;
                                        rw       <= shift_in[0];
                                    end else begin
                                        state <= S_WAIT_STOP;
                                    end
                                end else if (rx_ready) begin
                                    rx_data  <= shift_in;
                                    rx_valid <= 1'b1;
                                    state    <= S_WR_ACK;
                                end else begin
                                    state    <= S_WAIT_STOP;
                                    addr_hit <= 1'b0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    S_ADDR_ACK, S_WR_ACK: begin
                        if (hold_done)
                            sda_oe <= 1'b1;
                        if (scl_rise)
                            state <= (state == S_ADDR_ACK && rw) ? S_RD_LOAD : S_WR_BYTE;
                    end
                    S_RD_LOAD: begin
                        if (scl_fall) begin
                            tx_ready <= 1'b1;
                            if (STRETCH)
                                scl_oe <= 1'b1;
                        end
                        if (hs) begin
                            shreg    <= tx_data;
                            loaded   <= 1'b1;
                            tx_ready <= 1'b0;
                            if (STRETCH)
                                hold_cnt <= HOLD_INIT;
                        end
                        if (hold_done) begin
                            if (loaded || (!STRETCH && hs)) begin
                                shreg   <= load_byte;
                                sda_oe  <= ~load_byte[7];
                                scl_oe  <= 1'b0;
                                loaded  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= S_RD_BYTE;
                            end else if (!STRETCH) begin
                                shreg       <= 8'hFF;
                                sda_oe      <= 1'b0;
                                tx_underrun <= 1'b1;
                                tx_ready    <= 1'b0;
                                bit_cnt     <= '0;
                                state       <= S_RD_BYTE;
                            end else begin
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    S_RD_BYTE: begin
                        if (scl_rise)
                            bit_cnt <= bit_cnt + 4'd1;
                        if (hold_done) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= S_RD_ACK;
                            end else begin
                                sda_oe <= ~shreg[6];
                                shreg  <= {shreg[6:0], 1'b0};
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (scl_rise) begin
                            if (!sda_s) begin
                                state <= S_RD_LOAD;
                            end else begin
                                state    <= S_WAIT_STOP;
                                addr_hit <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bit-banged I2C controller driving i2c_target_responder over a wired-AND bus, with an rx scoreboard.
module tb_i2c_target_responder;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m_scl, m_sda;
    logic       scl_bus, sda_bus;
    logic       scl_oe, sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic       start_det, stop_det, addr_hit, rw, tx_underrun;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] tx_q[$];
    bit         tx_en;
    int         n_start = 0, n_stop = 0, n_under = 0, n_hs = 0;
    bit         sda_watch = 1'b0;
    int         sda_drive_cnt = 0;
    int         max_stretch = 0;
    logic [7:0] exp_b;
    bit         ack;
    logic [7:0] rd;
    int         s0, h0, u0, p0;

    always #5 clk = ~clk;

    assign scl_bus = m_scl & ~scl_oe;
    assign sda_bus = m_sda & ~sda_oe;

    i2c_target_responder #(
        .TARGET_ADDR(7'h22),
        .SYNC_STAGES(2),
        .HOLD_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .scl_i(scl_bus),
        .sda_i(sda_bus),
        .scl_oe(scl_oe),
        .sda_oe(sda_oe),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .start_det(start_det),
        .stop_det(stop_det),
        .addr_hit(addr_hit),
        .rw(rw),
        .tx_underrun(tx_underrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every rx_valid pulse must match the oldest expected byte.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                if (exp_rx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got %0h, required no rx_valid", rx_data);
                end else begin
                    exp_b = exp_rx.pop_front();
                    check("rx_data", {24'd0, rx_data}, {24'd0, exp_b});
                end
            end
            if (start_det)             n_start++;
            if (stop_det)              n_stop++;
            if (tx_underrun)           n_under++;
            if (tx_valid && tx_ready)  n_hs++;
            if (sda_watch && sda_oe)   sda_drive_cnt++;
        end
    end

    // tx source: presents the head of tx_q, pops on handshake.
    initial begin
        bit hs;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        forever begin
            @(negedge clk);
            hs = tx_valid && tx_ready;
            @(posedge clk);
            #1;
            if (hs && tx_q.size() > 0)
                void'(tx_q.pop_front());
            tx_valid = tx_en && (tx_q.size() > 0);
            tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: no finish within 60000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scl_release();
        int t;
        m_scl = 1'b1;
        t = 0;
        while (scl_bus !== 1'b1 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t > max_stretch) max_stretch = t;
        if (t >= 3000) begin
            checks++;
            errors++;
            $display("FAIL scl_timeout: SCL held low %0d cycles, required release", t);
        end
    endtask

    task automatic clock_bit(input bit b, output bit s);
        wclk(Q);
        m_sda = b;
        wclk(Q);
        scl_release();
        wclk(Q);
        s = sda_bus;
        wclk(Q);
        m_scl = 1'b0;
    endtask

    task automatic m_start();
        wclk(Q);
        m_sda = 1'b1;
        wclk(Q);
        scl_release();
        wclk(Q);
        m_sda = 1'b0;
        wclk(Q);
        m_scl = 1'b0;
    endtask

    task automatic m_stop();
        wclk(Q);
        m_sda = 1'b0;
        wclk(Q);
        scl_release();
        wclk(Q);
        m_sda = 1'b1;
        wclk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output bit a);
        bit s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, a);
    endtask

    task automatic read_byte(input bit nack, output logic [7:0] d);
        bit s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(nack, s);
    endtask

    initial begin
        rst_n    = 1'b0;
        m_scl    = 1'b1;
        m_sda    = 1'b1;
        rx_ready = 1'b1;
        tx_en    = 1'b1;
        wclk(3);
        check("reset_lines", {30'd0, scl_oe, sda_oe}, 32'd0);
        check("reset_flags", {25'd0, rx_valid, tx_ready, start_det, stop_det, addr_hit, rw, tx_underrun}, 32'd0);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        rst_n = 1'b1;
        wclk(5);

        // Write A5, 3C to 0x22
        s0 = n_start; p0 = n_stop;
        m_start();
        write_byte(8'h44, ack);
        check("wr_addr_ack", {31'd0, ack}, 32'd0);
        check("wr_hit_rw", {30'd0, addr_hit, rw}, 32'b10);
        exp_rx.push_back(8'hA5);
        write_byte(8'hA5, ack);
        check("wr_a5_ack", {31'd0, ack}, 32'd0);
        exp_rx.push_back(8'h3C);
        write_byte(8'h3C, ack);
        check("wr_3c_ack", {31'd0, ack}, 32'd0);
        m_stop();
        check("wr_start_cnt", n_start - s0, 32'd1);
        check("wr_stop_cnt", n_stop - p0, 32'd1);
        check("wr_hit_after_stop", {31'd0, addr_hit}, 32'd0);

        // Wrong address 0x23: target stays passive
        sda_watch = 1'b1;
        m_start();
        write_byte(8'h46, ack);
        check("bad_addr_nack", {31'd0, ack}, 32'd1);
        write_byte(8'h00, ack);
        check("bad_data_nack", {31'd0, ack}, 32'd1);
        m_stop();
        sda_watch = 1'b0;
        check("bad_sda_driven", sda_drive_cnt, 32'd0);

        // Sink not ready: data byte NACKed, hit drops
        m_start();
        write_byte(8'h44, ack);
        check("nrdy_addr_ack", {31'd0, ack}, 32'd0);
        rx_ready = 1'b0;
        write_byte(8'h99, ack);
        check("nrdy_data_nack", {31'd0, ack}, 32'd1);
        check("nrdy_hit", {31'd0, addr_hit}, 32'd0);
        rx_ready = 1'b1;
        m_stop();

        // Read 5A then C3 from 0x22
        h0 = n_hs;
        tx_q.push_back(8'h5A);
        tx_q.push_back(8'hC3);
        m_start();
        write_byte(8'h45, ack);
        check("rd_addr_ack", {31'd0, ack}, 32'd0);
        check("rd_hit_rw", {30'd0, addr_hit, rw}, 32'b11);
        read_byte(1'b0, rd);
        check("rd_byte0", {24'd0, rd}, 32'h5A);
        read_byte(1'b1, rd);
        check("rd_byte1", {24'd0, rd}, 32'hC3);
        check("rd_handshakes", n_hs - h0, 32'd2);
        check("rd_after_nack", {29'd0, addr_hit, tx_ready, sda_oe}, 32'd0);
        m_stop();

        // Write 11, repeated START, read A9
        s0 = n_start;
        m_start();
        write_byte(8'h44, ack);
        check("sr_wr_ack", {31'd0, ack}, 32'd0);
        check("sr_rw_wr", {31'd0, rw}, 32'd0);
        exp_rx.push_back(8'h11);
        write_byte(8'h11, ack);
        check("sr_data_ack", {31'd0, ack}, 32'd0);
        tx_q.push_back(8'hA9);
        m_start();
        write_byte(8'h45, ack);
        check("sr_rd_ack", {31'd0, ack}, 32'd0);
        check("sr_rw_rd", {31'd0, rw}, 32'd1);
        wclk(2);
        check("sr_ack_held_after_fall", {31'd0, sda_oe}, 32'd1);
        wclk(Q - 2);
        check("sr_bit7_driven", {31'd0, sda_oe}, 32'd0);
        read_byte(1'b1, rd);
        check("sr_rd_byte", {24'd0, rd}, 32'hA9);
        check("sr_start_cnt", n_start - s0, 32'd2);
        m_stop();

        // No tx byte available
        u0 = n_under;
        m_start();
        write_byte(8'h45, ack);
        check("ur_addr_ack", {31'd0, ack}, 32'd0);
`ifdef I2C_TARGET_CLK_STRETCH_EN
        max_stretch = 0;
        fork
            begin
                wclk(200);
                tx_q.push_back(8'h3A);
            end
        join_none
        read_byte(1'b1, rd);
        check("st_rd_byte", {24'd0, rd}, 32'h3A);
        check("st_long_stretch", {31'd0, (max_stretch >= 150 && max_stretch <= 260)}, 32'd1);
        check("st_no_underrun", n_under - u0, 32'd0);
`else
        read_byte(1'b1, rd);
        check("ur_rd_byte", {24'd0, rd}, 32'hFF);
        check("ur_pulses", n_under - u0, 32'd1);
        check("ur_scl_oe", {31'd0, scl_oe}, 32'd0);
`endif
        m_stop();

        // Reset in the middle of a read 0 bit, then a normal write
        tx_q.push_back(8'h00);
        m_start();
        write_byte(8'h45, ack);
        check("rst_addr_ack", {31'd0, ack}, 32'd0);
        for (int i = 0; i < 3; i++) clock_bit(1'b1, ack);
        wclk(Q);
        check("rst_bit4_driven", {31'd0, sda_oe}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_sda_release", {31'd0, sda_oe}, 32'd0);
        wclk(3);
        check("rst_hit_clear", {30'd0, addr_hit, scl_oe}, 32'd0);
        rst_n = 1'b1;
        m_start();
        write_byte(8'h44, ack);
        check("post_rst_addr_ack", {31'd0, ack}, 32'd0);
        exp_rx.push_back(8'h77);
        write_byte(8'h77, ack);
        check("post_rst_data_ack", {31'd0, ack}, 32'd0);
        m_stop();

        wclk(10);
        check("rx_queue_drained", exp_rx.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
